// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the slow-clock measurement block.
package clk_meas_pkg;

    localparam int unsigned FactorWidth = 5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2
    } meas_state_e;

    // Bit index of a single-bit value; 0 when not a power of two or when v == 1.
    function automatic logic [FactorWidth-1:0] log2_pow2(input logic [31:0] v);
        logic [FactorWidth-1:0] k;
        k = '0;
        if (v > 32'd1 && (v & (v - 32'd1)) == 32'd0) begin
            for (int i = 0; i < 32; i++) begin
                if (v[i]) k = FactorWidth'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/clk_meas_if.sv
// Control input, clock under test and measurement results of clk_meas.
interface clk_meas_if
    import clk_meas_pkg::*;
#(
    parameter int unsigned SIZE = 32
);
    logic                   clk_meas_en;
    logic                   clk_meas_in;
    logic [SIZE-1:0]        clk_meas_period;
    logic [SIZE-1:0]        clk_meas_high;
    logic [FactorWidth-1:0] clk_meas_factor;
    logic                   clk_meas_valid;
    logic                   clk_meas_done;
    logic                   clk_meas_stable;
    logic                   clk_meas_timeout;

    modport master (
        output clk_meas_en, clk_meas_in,
        input  clk_meas_period, clk_meas_high, clk_meas_factor,
        input  clk_meas_valid, clk_meas_done, clk_meas_stable, clk_meas_timeout
    );

    modport slave (
        input  clk_meas_en, clk_meas_in,
        output clk_meas_period, clk_meas_high, clk_meas_factor,
        output clk_meas_valid, clk_meas_done, clk_meas_stable, clk_meas_timeout
    );
endinterface

// File: rtl/clk_meas_sync.sv
// Multi-stage synchronizer for the slow input plus a registered rising-edge detector.
module clk_meas_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/clk_meas.sv
// Measures period, high time and power-of-two divide factor of an asynchronous
// slow clock in fsys cycles, with done/stable/timeout status.
module clk_meas
    import clk_meas_pkg::*;
#(
    parameter int unsigned SIZE        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk_meas_fsys,
    input logic       clk_meas_rst,
    clk_meas_if.slave bus
);
    meas_state_e            state_q, state_d;
    logic [SIZE-1:0]        cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [SIZE-1:0]        period_q, period_d, high_q, high_d;
    logic [FactorWidth-1:0] factor_q, factor_d;
    logic                   valid_q, valid_d, done_q, done_d;
    logic                   stable_q, stable_d, timeout_q, timeout_d;
    logic                   level, rise, cnt_sat;

    clk_meas_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_meas_fsys),
        .rst_i  (clk_meas_rst),
        .in_i   (bus.clk_meas_in),
        .level_o(level),
        .rise_o (rise)
    );

    assign cnt_sat = (cnt_q == '1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        factor_d  = factor_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        stable_d  = stable_q;
        timeout_d = timeout_q;

        // Both counters saturate rather than wrap.
        if (rise) cnt_d = SIZE'(1);
        else if (!cnt_sat) cnt_d = cnt_q + SIZE'(1);
        if (rise) hcnt_d = SIZE'(1);
        else if (level && hcnt_q != '1) hcnt_d = hcnt_q + SIZE'(1);

        if (!bus.clk_meas_en) begin
            state_d   = StIdle;
            cnt_d     = '0;
            hcnt_d    = '0;
            valid_d   = 1'b0;
            stable_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (rise) state_d = StMeasure;
                end
                StMeasure: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        factor_d  = log2_pow2(32'(cnt_q));
                        valid_d   = 1'b1;
                        done_d    = 1'b1;
                        timeout_d = 1'b0;
                        stable_d  = valid_q && (cnt_q == period_q);
                    end else if (cnt_sat) begin
                        timeout_d = 1'b1;
                        valid_d   = 1'b0;
                        stable_d  = 1'b0;
                        state_d   = StArm;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_meas_fsys or posedge clk_meas_rst) begin
        if (clk_meas_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            factor_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            stable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            factor_q  <= factor_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            stable_q  <= stable_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.clk_meas_period  = period_q;
    assign bus.clk_meas_high    = high_q;
    assign bus.clk_meas_factor  = factor_q;
    assign bus.clk_meas_valid   = valid_q;
    assign bus.clk_meas_done    = done_q;
    assign bus.clk_meas_stable  = stable_q;
    assign bus.clk_meas_timeout = timeout_q;
endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas (SIZE=8): pattern generator on the slow input,
// immediate-assertion checks at each step.
module tb_clk_meas;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Slow-input pattern: high gen_hi fsys cycles then low gen_lo, while gen_run.
    int   gen_hi  = 4;
    int   gen_lo  = 4;
    bit   gen_run = 1'b0;

    clk_meas_if #(.SIZE(8)) bus ();

    clk_meas #(
        .SIZE       (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_meas_fsys(clk),
        .clk_meas_rst (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        int gh;
        int gl;
        bus.clk_meas_in = 1'b0;
        forever begin
            if (gen_run) begin
                gh = gen_hi;
                gl = gen_lo;
                bus.clk_meas_in = 1'b1;
                repeat (gh) @(posedge clk);
                #1;
                bus.clk_meas_in = 1'b0;
                repeat (gl) @(posedge clk);
                #1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the caller on the negedge where done is high; n = negedges waited.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.clk_meas_done !== 1'b1 && n < 300);
        chk({tag, "_done_seen"}, 32'(bus.clk_meas_done), 32'd1);
    endtask

    // Skip transitional measurements until the expected period appears.
    task automatic wait_period(input string tag, input logic [7:0] p);
        int n;
        int k;
        k = 0;
        do begin
            wait_done(tag, n);
            k++;
        end while (bus.clk_meas_period !== p && k < 6);
        chk({tag, "_period"}, 32'(bus.clk_meas_period), 32'(p));
    endtask

    initial begin
        int n;
        int dcount;
        bus.clk_meas_en = 1'b0;

        // Reset state
        #3;
        chk("rst_period", 32'(bus.clk_meas_period), 32'd0);
        chk("rst_flags", {28'd0, bus.clk_meas_valid, bus.clk_meas_done,
                          bus.clk_meas_stable, bus.clk_meas_timeout}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // 1: factor 3
        gen_hi = 4; gen_lo = 4; gen_run = 1'b1;
        bus.clk_meas_en = 1'b1;
        wait_done("f3", n);
        chk("f3_period", 32'(bus.clk_meas_period), 32'd8);
        chk("f3_high", 32'(bus.clk_meas_high), 32'd4);
        chk("f3_factor", 32'(bus.clk_meas_factor), 32'd3);
        chk("f3_valid", 32'(bus.clk_meas_valid), 32'd1);
        chk("f3_stable0", 32'(bus.clk_meas_stable), 32'd0);
        @(negedge clk);
        chk("f3_done_pulse", 32'(bus.clk_meas_done), 32'd0);
        wait_done("f3b", n);
        chk("f3_stable1", 32'(bus.clk_meas_stable), 32'd1);
        chk("f3b_period", 32'(bus.clk_meas_period), 32'd8);

        // 2: factor 1, toggling every fsys cycle
        gen_hi = 1; gen_lo = 1;
        wait_period("f1", 8'd2);
        chk("f1_high", 32'(bus.clk_meas_high), 32'd1);
        chk("f1_factor", 32'(bus.clk_meas_factor), 32'd1);
        chk("f1_stable0", 32'(bus.clk_meas_stable), 32'd0);
        @(negedge clk);
        chk("f1_gap", 32'(bus.clk_meas_done), 32'd0);
        @(negedge clk);
        chk("f1_every2", 32'(bus.clk_meas_done), 32'd1);
        chk("f1_stable1", 32'(bus.clk_meas_stable), 32'd1);

        // 3: non-power-of-two 3/4, then factor 4
        gen_hi = 3; gen_lo = 4;
        wait_period("c7", 8'd7);
        wait_done("c7b", n);
        chk("c7_period", 32'(bus.clk_meas_period), 32'd7);
        chk("c7_high", 32'(bus.clk_meas_high), 32'd3);
        chk("c7_factor", 32'(bus.clk_meas_factor), 32'd0);
        chk("c7_stable", 32'(bus.clk_meas_stable), 32'd1);
        gen_hi = 8; gen_lo = 8;
        wait_period("f4", 8'd16);
        chk("f4_stable0", 32'(bus.clk_meas_stable), 32'd0);
        wait_done("f4b", n);
        chk("f4_stable1", 32'(bus.clk_meas_stable), 32'd1);
        chk("f4_factor", 32'(bus.clk_meas_factor), 32'd4);
        chk("f4_high", 32'(bus.clk_meas_high), 32'd8);

        // 4: frozen input saturates the 8-bit counter
        gen_run = 1'b0;
        repeat (200) @(negedge clk);
        chk("to_not_early", 32'(bus.clk_meas_timeout), 32'd0);
        n = 0;
        while (bus.clk_meas_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_set", 32'(bus.clk_meas_timeout), 32'd1);
        chk("to_valid", 32'(bus.clk_meas_valid), 32'd0);
        chk("to_stable", 32'(bus.clk_meas_stable), 32'd0);
        chk("to_period_hold", 32'(bus.clk_meas_period), 32'd16);
        gen_hi = 2; gen_lo = 2; gen_run = 1'b1;
        wait_done("f2", n);
        chk("f2_timeout_clr", 32'(bus.clk_meas_timeout), 32'd0);
        chk("f2_period", 32'(bus.clk_meas_period), 32'd4);
        chk("f2_factor", 32'(bus.clk_meas_factor), 32'd2);
        chk("f2_valid", 32'(bus.clk_meas_valid), 32'd1);

        // 5: enable dropped mid-period
        @(negedge clk);
        bus.clk_meas_en = 1'b0;
        @(negedge clk);
        chk("en_valid", 32'(bus.clk_meas_valid), 32'd0);
        chk("en_stable", 32'(bus.clk_meas_stable), 32'd0);
        chk("en_period_hold", 32'(bus.clk_meas_period), 32'd4);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.clk_meas_done === 1'b1) dcount++;
        end
        chk("en_no_done", 32'(dcount), 32'd0);
        bus.clk_meas_en = 1'b1;
        wait_done("ren", n);
        chk("ren_two_rises", 32'(n >= 6), 32'd1);
        chk("ren_period", 32'(bus.clk_meas_period), 32'd4);

        // 6: asynchronous reset mid-measurement
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_period", 32'(bus.clk_meas_period), 32'd0);
        chk("arst_high", 32'(bus.clk_meas_high), 32'd0);
        chk("arst_factor", 32'(bus.clk_meas_factor), 32'd0);
        chk("arst_flags", {28'd0, bus.clk_meas_valid, bus.clk_meas_done,
                           bus.clk_meas_stable, bus.clk_meas_timeout}, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("arst_valid_after", 32'(bus.clk_meas_valid), 32'd0);
        wait_done("arst", n);
        chk("arst_two_rises", 32'(n >= 5), 32'd1);
        chk("arst_period_new", 32'(bus.clk_meas_period), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
